vga_rx_decoder: RTL and testbench
=================================

// Module: vga_rx_decoder
// PURPOSE
//  Sink-side counterpart of the 800x600@60 VGA timing generator: takes sync/RGB
//  stream on the same clock, recovers pixel coordinates, checks timing against
//  nominal, declares lock. Feeds loopback checkers / frame capture in the game.
// PARAMETERS
//  H_SYNC 128, H_BP 88, H_ACTIVE 800, H_TOTAL 1056 : horizontal timing (clocks)
//  V_SYNC 4, V_BP 23, V_ACTIVE 600, V_TOTAL 628    : vertical timing (lines)
//  LOCK_FRAMES 2 : consecutive good frames required to lock (1..15)
// PORTS
//  clk_40mhz   in   1   pixel clock
//  rst_n       in   1   reset, asynchronous, active-low
//  vga_hs      in   1   hsync, active-low
//  vga_vs      in   1   vsync, active-low
//  vga_rgb     in   24  pixel data
//  pix_valid   out  1   active pixel strobe (only while locked)
//  pix_x       out  10  column 0..799, 0 when !pix_valid
//  pix_y       out  10  row 0..599, 0 when !pix_valid
//  pix_rgb     out  24  pixel data, 0 when !pix_valid
//  frame_start out  1   1-cycle pulse, vs falling edge while locked
//  locked      out  1   timing lock
//  err_cnt     out  8   timing errors, saturates at 255
//  frame_crc   out  16  CRC of last complete locked frame (see CONFIG)
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, state SEARCH, sync regs = 1 (idle high).
//  - Stage 1: register hs/vs/rgb; stage-2 copy of hs/vs for edge detect.
//    Fall = stage1==0 && stage2==1. Outputs registered -> 2 clk input-to-output.
//  - hcnt (11b): 0 on hs fall, else +1, saturate 2047. vcnt (10b): 0 on vs fall
//    (priority over hs fall in same cycle), else +1 on hs fall.
//  - Line error: hs fall with hcnt != H_TOTAL-1, or hcnt reaching 2047 (one
//    error per timeout, not per cycle). Frame error: vs fall with vcnt != V_TOTAL-1.
//  - FSM: SEARCH: no checks; vs fall -> ACQUIRE, good=0.
//    ACQUIRE: any error -> SEARCH, err_cnt+1; vs fall w/o error -> good+1;
//    good reaches LOCK_FRAMES -> LOCKED (locked=1 from next cycle).
//    LOCKED: any error -> SEARCH, locked=0 next cycle, err_cnt+1.
//    Line+frame error same cycle: err_cnt +1 only.
//  - Active: locked && hcnt in [H_SYNC+H_BP, +H_ACTIVE) && vcnt in
//    [V_SYNC+V_BP, +V_ACTIVE); pix_x=hcnt-(H_SYNC+H_BP), pix_y=vcnt-(V_SYNC+V_BP),
//    truncated to 10b; pix_rgb = stage-1 rgb.
//  - Nominal stream: hs/vs fall together at line 0 col 0; first pixel is
//    216 clks after hs fall on line 27 -> 480000 pix_valid per frame.
//  - Lock lost mid-line: pix_valid drops same cycle as locked.
// CONFIGURATION
//  VGA_RX_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF), 24 bits per
//  valid pixel MSB-first in one clock; at vs fall while locked, frame_crc <=
//  running CRC and CRC re-inits; on lock loss CRC re-inits, frame_crc holds.
//  Not defined: no CRC logic, frame_crc tied to 16'h0000.
// TESTING
//  1 Reset, hs=vs=1 idle -> locked=0, err_cnt=0, all outputs 0.
//  2 Ideal stream, LOCK_FRAMES=2 -> locked at 3rd vs fall; frame 3: 480000
//    pix_valid, first x=0,y=0 rgb equal to input 2 clks earlier, last x=799,y=599.
//  3 Locked, one line 1055 clks -> locked=0 at that hs fall+1, err_cnt=1;
//    relock after 2 clean frames.
//  4 Locked, hs held high -> error at hcnt=2047, err_cnt+1 once, SEARCH.
//  5 Force 300 errors -> err_cnt=255; rst_n low mid-frame -> all outputs 0 async.
//  6 CRC_EN: constant rgb 24'hFF0000 frame -> frame_crc matches reference model.

Source files
------------

// File: rtl/vga_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rx_decoder
//  Description : Sink-side VGA timing decoder for the 800x600@60 stream. Recovers
//                pixel coordinates from hsync/vsync, checks line and frame
//                lengths against nominal timing, and declares lock after
//                LOCK_FRAMES consecutive clean frames. Active pixels are only
//                presented while locked.
//  Optional    : VGA_RX_CRC_EN - when defined, a CRC-16-CCITT is accumulated over
//                every presented pixel and latched into frame_crc at each
//                locked vsync fall. When undefined, frame_crc is tied to zero.
//  Ports       : clk_40mhz   - pixel clock
//                rst_n       - asynchronous active-low reset
//                vga_hs      - hsync in (active low)
//                vga_vs      - vsync in (active low)
//                vga_rgb     - 24-bit pixel data in
//                pix_valid   - active pixel strobe (locked only)
//                pix_x/pix_y - pixel column/row, 0 when not valid
//                pix_rgb     - pixel data, 0 when not valid
//                frame_start - one-cycle pulse at a locked vsync fall
//                locked      - timing lock indicator
//                err_cnt     - saturating timing error counter
//                frame_crc   - CRC of the last complete locked frame
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_rx_decoder #(
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int H_ACTIVE    = 800,
  parameter int H_TOTAL     = 1056,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 23,
  parameter int V_ACTIVE    = 600,
  parameter int V_TOTAL     = 628,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_40mhz,
  input  logic        rst_n,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [23:0] vga_rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_crc
);

  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_MAX   = 11'd2047;
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  good;

  // Input stage 1 (registered inputs) and stage 2 (edge-detect history).
  // Sync registers idle high so reset does not fake a falling edge.
  logic        hs_s1, hs_s2, vs_s1, vs_s2;
  logic [23:0] rgb_s1;

  logic [10:0] hcnt;
  logic [9:0]  vcnt;

  always_ff @(posedge clk_40mhz or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1  <= 1'b1;
      hs_s2  <= 1'b1;
      vs_s1  <= 1'b1;
      vs_s2  <= 1'b1;
      rgb_s1 <= 24'h0;
    end else begin
      hs_s1  <= vga_hs;
      hs_s2  <= hs_s1;
      vs_s1  <= vga_vs;
      vs_s2  <= vs_s1;
      rgb_s1 <= vga_rgb;
    end
  end

  logic hs_fall, vs_fall;
  assign hs_fall = !hs_s1 && hs_s2;
  assign vs_fall = !vs_s1 && vs_s2;

  // hcnt_nxt/vcnt_nxt are the coordinates of the sample currently in stage 1,
  // so the output register aligns position with stage-1 rgb.
  logic [10:0] hcnt_nxt;
  logic [9:0]  vcnt_nxt;
  assign hcnt_nxt = hs_fall ? 11'd0 : ((hcnt == H_MAX) ? H_MAX : hcnt + 11'd1);
  assign vcnt_nxt = vs_fall ? 10'd0 : (hs_fall ? vcnt + 10'd1 : vcnt);

  always_ff @(posedge clk_40mhz or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= 11'd0;
      vcnt <= 10'd0;
    end else begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
    end
  end

  // The timeout fires only on the step into saturation, so a stuck hsync
  // produces a single error rather than one per cycle.
  logic line_err, frame_err, any_err;
  assign line_err  = (hs_fall && (hcnt != H_LAST)) || (!hs_fall && (hcnt == H_MAX - 11'd1));
  assign frame_err = vs_fall && (vcnt != V_LAST);
  assign any_err   = line_err || frame_err;

  // Lock surviving this cycle; gating outputs with it makes pix_valid fall
  // in the same cycle as locked.
  logic stay_locked, in_active, pix_on;
  assign stay_locked = (state == ST_LOCKED) && !any_err;
  assign in_active   = (hcnt_nxt >= H_START) && (hcnt_nxt < H_END) &&
                       (vcnt_nxt >= V_START) && (vcnt_nxt < V_END);
  assign pix_on      = in_active && stay_locked;

  always_ff @(posedge clk_40mhz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SEARCH;
      good        <= 4'd0;
      locked      <= 1'b0;
      err_cnt     <= 8'd0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 24'h0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= vs_fall && stay_locked;
      pix_valid   <= pix_on;
      pix_x       <= pix_on ? 10'(hcnt_nxt - H_START) : 10'd0;
      pix_y       <= pix_on ? (vcnt_nxt - V_START) : 10'd0;
      pix_rgb     <= pix_on ? rgb_s1 : 24'h0;

      // Simultaneous line and frame errors count once.
      if ((state != ST_SEARCH) && any_err && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;

      case (state)
        ST_SEARCH: begin
          if (vs_fall) begin
            state <= ST_ACQUIRE;
            good  <= 4'd0;
          end
        end
        ST_ACQUIRE: begin
          if (any_err) begin
            state <= ST_SEARCH;
          end else if (vs_fall) begin
            if (good + 4'd1 >= LOCK_N) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else begin
              good <= good + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (any_err) begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_RX_CRC_EN
  // CRC-16-CCITT, 24 data bits per pixel consumed MSB-first in one clock.
  function automatic logic [15:0] crc_step24(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  logic [15:0] crc_run;

  always_ff @(posedge clk_40mhz or negedge rst_n) begin
    if (!rst_n) begin
      crc_run   <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else if (!stay_locked) begin
      // Not locked, or lock lost this cycle: restart, keep last result.
      crc_run <= 16'hFFFF;
    end else if (vs_fall) begin
      frame_crc <= crc_run;
      crc_run   <= 16'hFFFF;
    end else if (in_active) begin
      crc_run <= crc_step24(crc_run, rgb_s1);
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_rx_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vga_rx_decoder
//  Description : Scoreboard bench for vga_rx_decoder on a reduced raster.
//                The stream driver pushes each pixel it expects the decoder
//                to present; an independent monitor pops and compares
//                whenever pix_valid is high, and checks idle zeros otherwise.
//                Build with VGA_RX_CRC_EN to also check frame_crc.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rx_decoder;

  // Small raster: 20 clocks/line, 12 lines/frame, 10x5 active pixels.
  localparam int HS = 4, HB = 3, HA = 10, HT = 20;
  localparam int VS = 2, VB = 2, VA = 5,  VT = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic [23:0] rgb = 24'h0;

  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic        frame_start, locked;
  logic [7:0]  err_cnt;
  logic [15:0] frame_crc;

  vga_rx_decoder #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk_40mhz  (clk),
    .rst_n      (rst_n),
    .vga_hs     (hs),
    .vga_vs     (vs),
    .vga_rgb    (rgb),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_start(frame_start),
    .locked     (locked),
    .err_cnt    (err_cnt),
    .frame_crc  (frame_crc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] d;
    int          t;
  } px_t;

  px_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  pushed = 0;
  int  seen   = 0;
  int  fs_cnt = 0;
  bit  const_rgb = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_valid"},   32'(pix_valid),   32'd0);
    check({tag, "_pix_x"},       32'(pix_x),       32'd0);
    check({tag, "_pix_y"},       32'(pix_y),       32'd0);
    check({tag, "_pix_rgb"},     32'(pix_rgb),     32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_locked"},      32'(locked),      32'd0);
    check({tag, "_err_cnt"},     32'(err_cnt),     32'd0);
    check({tag, "_frame_crc"},   32'(frame_crc),   32'd0);
  endtask

  task automatic drive_px(input logic h, input logic v, input logic [23:0] d);
    @(negedge clk);
    hs  = h;
    vs  = v;
    rgb = d;
  endtask

  // One frame. short_line (>=0) is one clock short; stop_line (>=0) aborts
  // the frame at the start of that line. Pixels are expected only when
  // exp_px is set and lock still holds (up to and including the short line).
  task automatic drive_frame(input bit exp_px, input int short_line, input int stop_line);
    int          len;
    bit          act;
    logic [23:0] d;
    for (int ln = 0; ln < VT; ln++) begin
      if (ln == stop_line) return;
      len = (ln == short_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        act = (c >= HS + HB) && (c < HS + HB + HA) && (ln >= VS + VB) && (ln < VS + VB + VA);
        if (act)
          d = const_rgb ? 24'hFF0000 : {8'(c), 8'(ln), 8'hA5 ^ 8'(pushed)};
        else
          d = 24'hC0FFEE;
        @(negedge clk);
        hs  = (c < HS) ? 1'b0 : 1'b1;
        vs  = (ln < VS) ? 1'b0 : 1'b1;
        rgb = d;
        if (act && exp_px && (short_line < 0 || ln <= short_line)) begin
          q.push_back('{10'(c - HS - HB), 10'(ln - VS - VB), d, cyc + 2});
          pushed++;
        end
      end
    end
  endtask

  // Monitor: compares every presented pixel against the scoreboard.
  always @(negedge clk) begin
    px_t e;
    if (rst_n) begin
      if (frame_start) fs_cnt++;
      if (pix_valid) begin
        if (q.size() == 0) begin
          check("unexpected_pixel", {pix_x, pix_y, 12'h0}, 32'hFFFFFFFF);
        end else begin
          e = q.pop_front();
          seen++;
          check("pix_x",   32'(pix_x),   32'(e.x));
          check("pix_y",   32'(pix_y),   32'(e.y));
          check("pix_rgb", 32'(pix_rgb), 32'(e.d));
          check("pix_latency_cycle", 32'(cyc), 32'(e.t));
        end
      end else begin
        check("idle_outputs_zero", 32'(pix_x) | 32'(pix_y) | 32'(pix_rgb), 32'd0);
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc_ref_const(input int npix, input logic [23:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int p = 0; p < npix; p++) begin
      for (int b = 23; b >= 0; b--) begin
        fb = c[15] ^ d[b];
        c  = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction
`endif

  initial begin
    // 1: reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) drive_px(1'b1, 1'b1, 24'h0);
    check("idle_locked", 32'(locked), 32'd0);

    // 2: lock acquisition, locked from the 3rd vsync fall
    drive_frame(1'b0, -1, -1);
    drive_frame(1'b0, -1, -1);
    check("locked_before_3rd_vs", 32'(locked), 32'd0);
    drive_frame(1'b1, -1, -1);
    check("locked_after_3rd_vs", 32'(locked), 32'd1);
    check("frame3_pixel_count", 32'(seen), 32'd50);
    check("frame3_no_frame_start", 32'(fs_cnt), 32'd0);
    drive_frame(1'b1, -1, -1);
    check("frame4_pixel_count", 32'(seen), 32'd100);
    check("frame_start_one_cycle", 32'(fs_cnt), 32'd1);
    check("err_cnt_clean", 32'(err_cnt), 32'd0);

`ifdef VGA_RX_CRC_EN
    const_rgb = 1'b1;
    drive_frame(1'b1, -1, -1);
    const_rgb = 1'b0;
`endif

    // 3: one short line drops lock, relock after two clean frames
    drive_frame(1'b1, 6, -1);
    check("short_line_unlock", 32'(locked), 32'd0);
    check("short_line_err_cnt", 32'(err_cnt), 32'd1);
`ifdef VGA_RX_CRC_EN
    check("frame_crc_const_red", 32'(frame_crc), 32'(crc_ref_const(50, 24'hFF0000)));
`else
    check("frame_crc_tied_zero", 32'(frame_crc), 32'd0);
`endif
    drive_frame(1'b0, -1, -1);
    drive_frame(1'b0, -1, -1);
    check("relock_not_before_vs", 32'(locked), 32'd0);
    drive_frame(1'b1, -1, -1);
    check("relocked", 32'(locked), 32'd1);
    check("relock_err_cnt", 32'(err_cnt), 32'd1);

    // 4: hsync stuck high while locked -> single timeout error
    drive_frame(1'b1, -1, 7);
    repeat (1000) drive_px(1'b1, 1'b1, 24'h123456);
    check("hs_stuck_still_locked", 32'(locked), 32'd1);
    repeat (1100) drive_px(1'b1, 1'b1, 24'h123456);
    check("hs_timeout_unlock", 32'(locked), 32'd0);
    check("hs_timeout_err_once", 32'(err_cnt), 32'd2);

    // 5: error flood saturates err_cnt
    repeat (620) begin
      drive_px(1'b1, 1'b0, 24'h0);
      drive_px(1'b1, 1'b0, 24'h0);
      drive_px(1'b1, 1'b1, 24'h0);
      drive_px(1'b1, 1'b1, 24'h0);
    end
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);
    check("flood_unlocked", 32'(locked), 32'd0);

    // Relock, then asynchronous reset in the middle of a frame
    drive_frame(1'b0, -1, -1);
    drive_frame(1'b0, -1, -1);
    drive_frame(1'b1, -1, 5);
    check("midframe_locked", 32'(locked), 32'd1);
    check("midframe_err_cnt", 32'(err_cnt), 32'd255);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) drive_px(1'b1, 1'b1, 24'h0);
    check_all_zero("after_reset");

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    check("pixels_seen_total", 32'(seen), 32'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
